memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
- REQ-001 SHALL have parameter MISALIGN_CHECK, default 1, meaning misaligned accesses are flagged and never issued to the bus.
- REQ-002 SHALL have port clk  input  1  pipeline clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
- REQ-004 SHALL have port dataE  input  execute_data_t  execute-stage register: pc, alu (address or result), rs2 (store data), ctl (MemRead, MemWrite, msize[1:0], MemUnsigned), valid.
- REQ-005 SHALL have port stallM  input  1  memory-stage register is held this cycle.
- REQ-006 SHALL have port dreq  output  dbus_req_t  valid, addr[63:0], size[2:0], strobe[7:0], data[63:0].
- REQ-007 SHALL have port dresp  input  dbus_resp_t  data_ok, data[63:0].
- REQ-008 SHALL have port dataM_nxt  output  memory_data_t  pc, ctl, alu, rdata[63:0], misaligned, valid.
- REQ-009 SHALL have port mem_wait  output  1  request to stall all upstream stages.

Function
- REQ-010 Access: mem = dataE.valid & (MemRead | MemWrite) & ~misaligned.
- REQ-011 Misaligned: msize=1 & addr[0]; msize=2 & addr[1:0]!=0; msize=3 & addr[2:0]!=0; forced 0 when MISALIGN_CHECK=0.
- REQ-012 FSM states: IDLE, WAIT, HOLD; reset state IDLE.
- REQ-013 IDLE: mem=1 -> drive dreq.valid=1 same cycle; data_ok same cycle -> HOLD if stallM else stay IDLE; no data_ok -> WAIT.
- REQ-014 WAIT: dreq.valid=1 with fields held stable; data_ok -> HOLD if stallM else IDLE.
- REQ-015 HOLD: dreq.valid=0; latched rdata output; leaves to IDLE on first cycle with stallM=0.
- REQ-016 dreq.addr = dataE.alu; dreq.size = {1'b0, msize}.
- REQ-017 dreq.strobe: 0 for loads; stores: byte 8'h01<<a, half 8'h03<<a, word 8'h0F<<a, double 8'hFF (a = addr[2:0]).
- REQ-018 dreq.data = dataE.rs2 << (8*addr[2:0]).
- REQ-019 Load data: raw = dresp.data >> (8*addr[2:0]); truncate to msize; sign-extend to 64 unless MemUnsigned.
- REQ-020 dataM_nxt.rdata = extracted value in data_ok cycle, latched value in HOLD, 0 otherwise.
- REQ-021 mem_wait = (mem & state IDLE & ~data_ok) | (state WAIT & ~data_ok).
- REQ-022 mem_wait SHALL be 0 in HOLD and in every cycle where data_ok=1.
- REQ-023 dataM_nxt.pc, ctl, alu SHALL pass through dataE unchanged.
- REQ-024 dataM_nxt.misaligned SHALL equal the REQ-011 result gated by dataE.valid.
- REQ-025 dataM_nxt.valid = dataE.valid & ~mem_wait.
- REQ-026 Non-memory or invalid instruction: no bus request; mem_wait=0; single-cycle pass-through.
- REQ-027 A request SHALL never be withdrawn once dreq.valid=1 until data_ok.
- REQ-028 Exactly one bus transaction per instruction, including across stallM cycles (HOLD prevents reissue).
- REQ-029 data_ok while not in IDLE-with-request or WAIT SHALL be ignored.

Reset
- REQ-030 Reset asserted SHALL immediately force state IDLE, latched rdata 0, dreq.valid 0, mem_wait 0, independent of clk.
- REQ-031 Reset mid-WAIT SHALL abandon the transaction; a late data_ok after deassert SHALL be ignored per REQ-029.
- REQ-032 First request after reset deassert SHALL issue no earlier than the first rising edge with reset low.

Verification
- REQ-033 lb addr 0x1003, dresp.data 0x0000_0000_8000_0000 after 2-cycle delay -> mem_wait high 2 cycles, rdata 0xFFFF_FFFF_FFFF_FF80.
- REQ-034 lhu addr 0x1006, data 0xBEEF_0000_0000_0000, data_ok same cycle -> mem_wait 0, rdata 0x0000_0000_0000_BEEF.
- REQ-035 sw addr 0x2004, rs2 0x1234_5678 -> strobe 0xF0, data 0x1234_5678_0000_0000, rdata 0.
- REQ-036 ld addr 0x3004 with MISALIGN_CHECK=1 -> dreq.valid 0, misaligned 1, mem_wait 0.
- REQ-037 ld with data_ok while stallM=1 for 3 cycles -> HOLD, no second dreq.valid, rdata stable all 3 cycles.
- REQ-038 reset pulsed in WAIT, stray data_ok next cycle -> state IDLE, mem_wait 0, rdata 0.

Source files
------------

// File: rtl/memory.sv
// Memory stage: turns an execute-stage load/store into a single data-bus
// transaction, waits for completion, and aligns/extends load data.
// An access that would be misaligned is flagged and never reaches the bus.

package memory_pkg;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] msize;
        logic       mem_unsigned;
    } mem_ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] rs2;
        mem_ctl_t    ctl;
        logic        valid;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        mem_ctl_t    ctl;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic        misaligned;
        logic        valid;
    } memory_data_t;

endpackage

module memory
    import memory_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          stallM,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM_nxt,
    output logic          mem_wait
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [63:0] rdata_q;

    logic        mis;
    logic        mem;
    logic        req_valid;
    logic        ok;
    logic [63:0] load_val;

    function automatic logic misaligned_f(input logic [1:0] msize, input logic [2:0] a);
        case (msize)
            2'd1:    misaligned_f = a[0];
            2'd2:    misaligned_f = (a[1:0] != 2'd0);
            2'd3:    misaligned_f = (a != 3'd0);
            default: misaligned_f = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] strobe_f(input logic wr, input logic [1:0] msize,
                                            input logic [2:0] a);
        if (!wr) begin
            strobe_f = 8'h00;
        end else begin
            case (msize)
                2'd0:    strobe_f = 8'h01 << a;
                2'd1:    strobe_f = 8'h03 << a;
                2'd2:    strobe_f = 8'h0F << a;
                default: strobe_f = 8'hFF;
            endcase
        end
    endfunction

    function automatic logic [63:0] extract_load(input logic [63:0] data, input logic [2:0] a,
                                                 input logic [1:0] msize, input logic uns);
        logic [63:0] raw;
        raw = data >> {a, 3'b000};
        case (msize)
            2'd0:    extract_load = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    extract_load = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    extract_load = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: extract_load = raw;
        endcase
    endfunction

    // Request, handshake and output datapath; reset silences the bus immediately.
    always_comb begin
        mis       = MISALIGN_CHECK ? misaligned_f(dataE.ctl.msize, dataE.alu[2:0]) : 1'b0;
        mem       = dataE.valid & (dataE.ctl.mem_read | dataE.ctl.mem_write) & ~mis;
        req_valid = ~reset & (((state == IDLE) & mem) | (state == WAIT));
        ok        = req_valid & dresp.data_ok;
        load_val  = dataE.ctl.mem_read
                    ? extract_load(dresp.data, dataE.alu[2:0], dataE.ctl.msize,
                                   dataE.ctl.mem_unsigned)
                    : 64'd0;
        mem_wait  = req_valid & ~dresp.data_ok;

        dreq.valid  = req_valid;
        dreq.addr   = dataE.alu;
        dreq.size   = {1'b0, dataE.ctl.msize};
        dreq.strobe = strobe_f(dataE.ctl.mem_write, dataE.ctl.msize, dataE.alu[2:0]);
        dreq.data   = dataE.rs2 << {dataE.alu[2:0], 3'b000};

        dataM_nxt.pc         = dataE.pc;
        dataM_nxt.ctl        = dataE.ctl;
        dataM_nxt.alu        = dataE.alu;
        dataM_nxt.misaligned = mis & dataE.valid;
        dataM_nxt.valid      = dataE.valid & ~mem_wait;
        if (ok) begin
            dataM_nxt.rdata = load_val;
        end else if (state == HOLD) begin
            dataM_nxt.rdata = rdata_q;
        end else begin
            dataM_nxt.rdata = 64'd0;
        end
    end

    // Next-state: a completed access parks in HOLD while the stage is stalled.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem) begin
                    if (ok) begin
                        next_state = stallM ? HOLD : IDLE;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (ok) begin
                    next_state = stallM ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!stallM) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and load-data capture for replay during HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= 64'd0;
        end else begin
            state <= next_state;
            if (ok) begin
                rdata_q <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage: loads/stores with hand-computed bus
// fields and load data, misalignment, stall hold, and reset mid-transaction.

module tb_memory;
    import memory_pkg::*;

    logic          clk;
    logic          reset;
    execute_data_t dataE;
    logic          stallM;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM_nxt;
    logic          mem_wait;

    int n_cmp;
    int n_bad;

    memory #(.MISALIGN_CHECK(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .stallM    (stallM),
        .dreq      (dreq),
        .dresp     (dresp),
        .dataM_nxt (dataM_nxt),
        .mem_wait  (mem_wait)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [63:0] pc, input logic [63:0] alu,
                          input logic [63:0] rs2);
        dataE.valid            = v;
        dataE.ctl.mem_read     = rd;
        dataE.ctl.mem_write    = wr;
        dataE.ctl.msize        = sz;
        dataE.ctl.mem_unsigned = uns;
        dataE.pc               = pc;
        dataE.alu              = alu;
        dataE.rs2              = rs2;
    endtask

    task automatic set_resp(input logic ok, input logic [63:0] d);
        dresp.data_ok = ok;
        dresp.data    = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        clk    = 1'b0;
        reset  = 1'b1;
        stallM = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h100, 64'h1000, 64'd0);
        set_resp(1'b1, 64'hDEAD);

        // Reset held: bus silent even with a load presented and data_ok high
        #2;
        check("rst_dreq_valid", 64'(dreq.valid), 64'd0);
        check("rst_mem_wait",   64'(mem_wait),   64'd0);
        check("rst_rdata",      dataM_nxt.rdata, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'd0);
        set_resp(1'b0, 64'd0);
        #3;
        check("idle_dreq_valid", 64'(dreq.valid), 64'd0);

        // lb 0x1003, data arrives after two waiting cycles
        step();
        set_ex(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h400, 64'h1003, 64'd0);
        #3;
        check("lb_c1_dreq_valid", 64'(dreq.valid), 64'd1);
        check("lb_c1_mem_wait",   64'(mem_wait),   64'd1);
        check("lb_addr",          dreq.addr,       64'h1003);
        check("lb_size",          64'(dreq.size),  64'd0);
        check("lb_strobe",        64'(dreq.strobe), 64'd0);
        check("lb_c1_valid_out",  64'(dataM_nxt.valid), 64'd0);
        step();
        #3;
        check("lb_c2_dreq_valid", 64'(dreq.valid), 64'd1);
        check("lb_c2_mem_wait",   64'(mem_wait),   64'd1);
        check("lb_c2_addr",       dreq.addr,       64'h1003);
        step();
        set_resp(1'b1, 64'h0000_0000_8000_0000);
        #3;
        check("lb_c3_mem_wait",   64'(mem_wait),   64'd0);
        check("lb_rdata",         dataM_nxt.rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_c3_valid_out",  64'(dataM_nxt.valid), 64'd1);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'd0);
        set_resp(1'b0, 64'd0);
        #3;
        check("lb_after_dreq_valid", 64'(dreq.valid), 64'd0);

        // lhu 0x1006 with same-cycle data_ok
        step();
        set_ex(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 64'h404, 64'h1006, 64'd0);
        set_resp(1'b1, 64'hBEEF_0000_0000_0000);
        #3;
        check("lhu_dreq_valid", 64'(dreq.valid), 64'd1);
        check("lhu_mem_wait",   64'(mem_wait),   64'd0);
        check("lhu_rdata",      dataM_nxt.rdata, 64'h0000_0000_0000_BEEF);
        check("lhu_size",       64'(dreq.size),  64'd1);

        // lw 0x0004 signed, upper word negative
        step();
        set_ex(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h408, 64'h0004, 64'd0);
        set_resp(1'b1, 64'h8000_0000_0000_0000);
        #3;
        check("lw_rdata", dataM_nxt.rdata, 64'hFFFF_FFFF_8000_0000);

        // sw 0x2004
        step();
        set_ex(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 64'h40C, 64'h2004, 64'h0000_0000_1234_5678);
        set_resp(1'b1, 64'd0);
        #3;
        check("sw_strobe",   64'(dreq.strobe), 64'hF0);
        check("sw_data",     dreq.data,        64'h1234_5678_0000_0000);
        check("sw_rdata",    dataM_nxt.rdata,  64'd0);
        check("sw_mem_wait", 64'(mem_wait),    64'd0);

        // sb 0x5005
        step();
        set_ex(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 64'h410, 64'h5005, 64'h0000_0000_0000_00AB);
        #3;
        check("sb_strobe", 64'(dreq.strobe), 64'h20);
        check("sb_data",   dreq.data,        64'h0000_AB00_0000_0000);

        // ld 0x3004 is misaligned: flagged, never issued
        step();
        set_ex(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h414, 64'h3004, 64'd0);
        set_resp(1'b0, 64'd0);
        #3;
        check("mis_dreq_valid", 64'(dreq.valid),           64'd0);
        check("mis_flag",       64'(dataM_nxt.misaligned), 64'd1);
        check("mis_mem_wait",   64'(mem_wait),             64'd0);
        check("mis_valid_out",  64'(dataM_nxt.valid),      64'd1);

        // Non-memory instruction passes straight through
        step();
        set_ex(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h418, 64'h1234_5679, 64'h55);
        #3;
        check("alu_pc",         dataM_nxt.pc,              64'h418);
        check("alu_alu",        dataM_nxt.alu,             64'h1234_5679);
        check("alu_ctl",        64'(dataM_nxt.ctl),        64'd0);
        check("alu_valid_out",  64'(dataM_nxt.valid),      64'd1);
        check("alu_dreq_valid", 64'(dreq.valid),           64'd0);
        check("alu_mis",        64'(dataM_nxt.misaligned), 64'd0);

        // ld completes while stalled: HOLD replays data, no reissue
        step();
        set_ex(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h41C, 64'h4000, 64'd0);
        set_resp(1'b1, 64'h1122_3344_5566_7788);
        stallM = 1'b1;
        #3;
        check("hold_ok_rdata", dataM_nxt.rdata, 64'h1122_3344_5566_7788);
        for (int i = 0; i < 3; i++) begin
            step();
            set_resp(i == 1, 64'hAAAA_BBBB_CCCC_DDDD);
            #3;
            check("hold_dreq_valid", 64'(dreq.valid),   64'd0);
            check("hold_mem_wait",   64'(mem_wait),     64'd0);
            check("hold_rdata",      dataM_nxt.rdata,   64'h1122_3344_5566_7788);
        end
        step();
        stallM = 1'b0;
        set_resp(1'b0, 64'd0);
        #3;
        check("hold_release_rdata", dataM_nxt.rdata, 64'h1122_3344_5566_7788);
        check("hold_release_dreq",  64'(dreq.valid), 64'd0);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'd0);
        #3;
        check("post_hold_rdata", dataM_nxt.rdata, 64'd0);

        // Reset pulsed while waiting; a stray data_ok afterwards is ignored
        step();
        set_ex(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h420, 64'h6000, 64'd0);
        #3;
        check("rw_c1_mem_wait", 64'(mem_wait), 64'd1);
        step();
        #1;
        reset = 1'b1;
        #1;
        check("rw_async_dreq",     64'(dreq.valid), 64'd0);
        check("rw_async_mem_wait", 64'(mem_wait),   64'd0);
        check("rw_async_rdata",    dataM_nxt.rdata, 64'd0);
        reset = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 64'd0);
        #1;
        check("rw_idle_dreq", 64'(dreq.valid), 64'd0);
        step();
        set_resp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        #3;
        check("rw_stray_dreq",     64'(dreq.valid), 64'd0);
        check("rw_stray_mem_wait", 64'(mem_wait),   64'd0);
        check("rw_stray_rdata",    dataM_nxt.rdata, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
